// File: rtl/dft_accum_tdm.sv
// Time-multiplexed windowed DFT accumulator: one sample is spread over NUM_BINS cycles, one bin per cycle.
// Define DFT_ACCUM_TDM_SAT_EN for saturating accumulators with a sticky ovf_o; otherwise adds wrap.
module dft_accum_tdm #(
    parameter int IQ_WIDTH     = 16,
    parameter int WINDOW_WIDTH = 16,
    parameter int OSC_WIDTH    = 18,
    parameter int ACCUM_WIDTH  = 48,
    parameter int NUM_BINS     = 16,
    parameter int PROD_SHIFT   = 0,
    parameter int CNT_WIDTH    = 16,
    localparam int BW          = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic [IQ_WIDTH-1:0]     s_i_i,
    input  logic [IQ_WIDTH-1:0]     s_q_i,
    input  logic [WINDOW_WIDTH-1:0] s_h_i,
    input  logic                    s_last_i,
    output logic [BW-1:0]           w_bin_o,
    input  logic [OSC_WIDTH-1:0]    w_real_i,
    input  logic [OSC_WIDTH-1:0]    w_imag_i,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [BW-1:0]           m_bin_o,
    output logic [ACCUM_WIDTH-1:0]  m_real_o,
    output logic [ACCUM_WIDTH-1:0]  m_imag_o,
    output logic                    m_last_o,
    output logic [CNT_WIDTH-1:0]    count_o,
    output logic                    busy_o,
    output logic                    ovf_o
);
    localparam int AW = ACCUM_WIDTH;
    localparam int XW = IQ_WIDTH + WINDOW_WIDTH;
    localparam int PW = XW + OSC_WIDTH + 1;
    localparam int EW = (PW > AW) ? PW : AW;
    localparam logic [BW-1:0] LAST_BIN = BW'(NUM_BINS - 1);

    typedef enum logic [1:0] {IDLE, WAIT, PROC, OUT} state_e;

    state_e                state_q;
    logic [BW-1:0]         k_q, j_q;
    logic signed [XW-1:0]  xr_q, xi_q;
    logic                  last_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  ovf_q;
    logic signed [AW-1:0]  acc_r_q [NUM_BINS];
    logic signed [AW-1:0]  acc_i_q [NUM_BINS];

    logic signed [XW-1:0]  xr_d, xi_d;
    logic signed [PW-1:0]  xr_e, xi_e, wr_e, wi_e, pr_full, pi_full;
    logic signed [EW-1:0]  pr_ext, pi_ext;
    logic signed [AW-1:0]  cr, ci;
    logic [AW:0]           sum_r, sum_i;

    // Returns {overflow, result}; overflow is only ever raised in the saturating build.
    function automatic logic [AW:0] acc_add(input logic signed [AW-1:0] a,
                                            input logic signed [AW-1:0] b);
`ifdef DFT_ACCUM_TDM_SAT_EN
        logic signed [AW:0] s;
        s = (AW+1)'(a) + (AW+1)'(b);
        if (s[AW] != s[AW-1])
            return {1'b1, s[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}}};
        return {1'b0, s[AW-1:0]};
`else
        return {1'b0, a + b};
`endif
    endfunction

    assign xr_d = XW'($signed(s_i_i)) * XW'($signed(s_h_i));
    assign xi_d = XW'($signed(s_q_i)) * XW'($signed(s_h_i));

    assign xr_e    = PW'(xr_q);
    assign xi_e    = PW'(xi_q);
    assign wr_e    = PW'($signed(w_real_i));
    assign wi_e    = PW'($signed(w_imag_i));
    assign pr_full = (xr_e * wr_e - xi_e * wi_e) >>> PROD_SHIFT;
    assign pi_full = (xr_e * wi_e + xi_e * wr_e) >>> PROD_SHIFT;
    assign pr_ext  = EW'(pr_full);
    assign pi_ext  = EW'(pi_full);
    assign cr      = pr_ext[AW-1:0];
    assign ci      = pi_ext[AW-1:0];
    assign sum_r   = acc_add(acc_r_q[k_q], cr);
    assign sum_i   = acc_add(acc_i_q[k_q], ci);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            k_q     <= '0;
            j_q     <= '0;
            xr_q    <= '0;
            xi_q    <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            for (int b = 0; b < NUM_BINS; b++) begin
                acc_r_q[b] <= '0;
                acc_i_q[b] <= '0;
            end
        end else if (abort_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            j_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    cnt_q   <= '0;
                    ovf_q   <= 1'b0;
                    k_q     <= '0;
                    j_q     <= '0;
                    state_q <= WAIT;
                    for (int b = 0; b < NUM_BINS; b++) begin
                        acc_r_q[b] <= '0;
                        acc_i_q[b] <= '0;
                    end
                end
                WAIT: if (s_valid_i) begin
                    xr_q    <= xr_d;
                    xi_q    <= xi_d;
                    last_q  <= s_last_i;
                    if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                    k_q     <= '0;
                    state_q <= PROC;
                end
                PROC: begin
                    acc_r_q[k_q] <= sum_r[AW-1:0];
                    acc_i_q[k_q] <= sum_i[AW-1:0];
                    ovf_q        <= ovf_q | sum_r[AW] | sum_i[AW];
                    if (k_q == LAST_BIN) begin
                        k_q     <= '0;
                        j_q     <= '0;
                        state_q <= last_q ? OUT : WAIT;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                OUT: if (m_ready_i) begin
                    if (j_q == LAST_BIN) begin
                        j_q     <= '0;
                        state_q <= IDLE;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Result fields are gated so every output reads 0 whenever no beat is offered.
    assign s_ready_o = (state_q == WAIT);
    assign busy_o    = (state_q != IDLE);
    assign w_bin_o   = (state_q == PROC) ? k_q : '0;
    assign m_valid_o = (state_q == OUT);
    assign m_bin_o   = m_valid_o ? j_q : '0;
    assign m_real_o  = m_valid_o ? acc_r_q[j_q] : '0;
    assign m_imag_o  = m_valid_o ? acc_i_q[j_q] : '0;
    assign m_last_o  = m_valid_o && (j_q == LAST_BIN);
    assign count_o   = cnt_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_dft_accum_tdm.sv
// Scoreboard bench for dft_accum_tdm: driver pushes model results, a negedge monitor pops and compares.
module tb_dft_accum_tdm;
    localparam int IW = 8, HW = 8, OW = 10, AW = 20, NB = 4, SH = 0, CW = 16, BW = 2;
    localparam longint MAXV = (64'sd1 <<< (AW-1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (AW-1));

    logic clk = 1'b0, rst_ni = 1'b0;
    logic start_i = 1'b0, abort_i = 1'b0, s_valid_i = 1'b0, s_last_i = 1'b0, m_ready_i = 1'b0;
    logic [IW-1:0] s_i_i = '0, s_q_i = '0;
    logic [HW-1:0] s_h_i = '0;
    logic [OW-1:0] w_real_i, w_imag_i;
    logic s_ready_o, m_valid_o, m_last_o, busy_o, ovf_o;
    logic [BW-1:0] w_bin_o, m_bin_o;
    logic [AW-1:0] m_real_o, m_imag_o;
    logic [CW-1:0] count_o;

    int wr_int [NB];
    int wi_int [NB];
    assign w_real_i = OW'(wr_int[w_bin_o]);
    assign w_imag_i = OW'(wi_int[w_bin_o]);

    dft_accum_tdm #(.IQ_WIDTH(IW), .WINDOW_WIDTH(HW), .OSC_WIDTH(OW), .ACCUM_WIDTH(AW),
                    .NUM_BINS(NB), .PROD_SHIFT(SH), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_i_i(s_i_i), .s_q_i(s_q_i),
        .s_h_i(s_h_i), .s_last_i(s_last_i), .w_bin_o(w_bin_o), .w_real_i(w_real_i),
        .w_imag_i(w_imag_i), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_bin_o(m_bin_o),
        .m_real_o(m_real_o), .m_imag_o(m_imag_o), .m_last_o(m_last_o), .count_o(count_o),
        .busy_o(busy_o), .ovf_o(ovf_o));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: plain integer DFT accumulation per bin.
    typedef struct { int bin; longint re; longint im; bit last; } exp_t;
    exp_t exp_q[$];
    longint acc_r [NB];
    longint acc_i [NB];
    bit m_ovf;

    function automatic longint wrap_a(input longint v);
        longint m;
        m = v & ((64'sd1 <<< AW) - 1);
        if (m > MAXV) m = m - (64'sd1 <<< AW);
        return m;
    endfunction

    function automatic longint acc_add(input longint a, input longint c);
        longint s;
        s = a + c;
`ifdef DFT_ACCUM_TDM_SAT_EN
        if (s > MAXV) begin m_ovf = 1'b1; return MAXV; end
        if (s < MINV) begin m_ovf = 1'b1; return MINV; end
        return s;
`else
        return wrap_a(s);
`endif
    endfunction

    task automatic model_sample(input int si, input int sq, input int h);
        longint xr, xi, pr, pi;
        xr = longint'(si) * h;
        xi = longint'(sq) * h;
        for (int k = 0; k < NB; k++) begin
            pr = xr * wr_int[k] - xi * wi_int[k];
            pi = xr * wi_int[k] + xi * wr_int[k];
            acc_r[k] = acc_add(acc_r[k], wrap_a(pr >>> SH));
            acc_i[k] = acc_add(acc_i[k], wrap_a(pi >>> SH));
        end
    endtask

    function automatic bit exp_ovf();
`ifdef DFT_ACCUM_TDM_SAT_EN
        return m_ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Ready generator: random back-pressure or a level chosen by the driver.
    bit rdy_rand = 1'b0, rdy_force = 1'b1;
    always begin
        @(posedge clk);
        #2;
        m_ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    // Monitor: compares each accepted beat and checks holding under back-pressure.
    exp_t mon_e;
    bit stalled = 1'b0;
    logic [BW-1:0] pv_bin;
    logic [AW-1:0] pv_re, pv_im;
    always @(negedge clk) begin
        if (!rst_ni) begin
            stalled = 1'b0;
        end else if (m_valid_o) begin
            if (stalled) begin
                chk("hold_bin", m_bin_o, pv_bin);
                chk("hold_real", $signed(m_real_o), $signed(pv_re));
                chk("hold_imag", $signed(m_imag_o), $signed(pv_im));
            end
            if (m_ready_i && !abort_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: bin %0d arrived, none expected", m_bin_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_bin", m_bin_o, mon_e.bin);
                    chk("beat_real", $signed(m_real_o), mon_e.re);
                    chk("beat_imag", $signed(m_imag_o), mon_e.im);
                    chk("beat_last", m_last_o, mon_e.last);
                end
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                pv_bin  = m_bin_o;
                pv_re   = m_real_o;
                pv_im   = m_imag_o;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        start_i = 1'b1;
        for (int k = 0; k < NB; k++) begin acc_r[k] = 0; acc_i[k] = 0; end
        m_ovf = 1'b0;
        cyc();
        start_i = 1'b0;
    endtask

    task automatic rand_w();
        for (int k = 0; k < NB; k++) begin
            wr_int[k] = int'($urandom_range(0, 1023)) - 512;
            wi_int[k] = int'($urandom_range(0, 1023)) - 512;
        end
    endtask

    task automatic send_sample(input int si, input int sq, input int h, input bit last, input bit randw);
        bit ok;
        ok = 1'b0;
        s_i_i = IW'(si); s_q_i = IW'(sq); s_h_i = HW'(h);
        s_last_i = last; s_valid_i = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (s_ready_o) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL sample_accept: s_ready_o never rose, expected within 200 cycles");
        end else begin
            if (randw) rand_w();
            model_sample(si, sq, h);
        end
        cyc();
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    task automatic push_expected();
        exp_t e;
        for (int k = 0; k < NB; k++) begin
            e.bin = k; e.re = acc_r[k]; e.im = acc_i[k]; e.last = (k == NB-1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_valid();
        int c;
        c = 0;
        while (!m_valid_o && c < 200) begin cyc(); c++; end
        chk("out_reached", m_valid_o, 1);
    endtask

    task automatic wait_idle(input int n);
        int c;
        c = 0;
        while (busy_o && c < 2000) begin cyc(); c++; end
        chk("frame_done", busy_o, 0);
        chk("count", count_o, n);
        chk("ovf", ovf_o, exp_ovf());
        chk("queue_drained", exp_q.size(), 0);
    endtask

    function automatic int rnd_val(input int bits);
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 15)) - 8;
        return int'($urandom_range(0, (1 << bits) - 1)) - (1 << (bits - 1));
    endfunction

    initial begin
        int n, bad;
        for (int k = 0; k < NB; k++) begin wr_int[k] = 1; wi_int[k] = 0; end

        // Outputs while reset is held
        #3;
        chk("rst_busy", busy_o, 0);
        chk("rst_s_ready", s_ready_o, 0);
        chk("rst_m_valid", m_valid_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_w_bin", w_bin_o, 0);
        cyc();
        rst_ni = 1'b1;
        cyc(); cyc();
        chk("idle_after_release", busy_o, 0);

        // Five identical samples, unit oscillator, stall of 3 cycles on bin 1
        rdy_rand = 1'b0; rdy_force = 1'b0;
        start_frame();
        for (int s = 0; s < 5; s++) send_sample(3, -2, 1, s == 4, 1'b0);
        push_expected();
        wait_valid();
        rdy_force = 1'b1;
        cyc();
        rdy_force = 1'b0;
        cyc(); cyc(); cyc();
        chk("stall_bin", m_bin_o, 1);
        rdy_force = 1'b1;
        wait_idle(5);

        // Bin 2 oscillator rotated by 90 degrees
        for (int k = 0; k < NB; k++) begin wr_int[k] = k + 2; wi_int[k] = -k; end
        wr_int[2] = 0; wi_int[2] = 1;
        start_frame();
        send_sample(4, 1, 2, 1'b1, 1'b0);
        push_expected();
        wait_idle(1);

        // Accumulator overflow: two contributions of 300000 each
        for (int k = 0; k < NB; k++) begin wr_int[k] = 30; wi_int[k] = 0; end
        start_frame();
        send_sample(100, 0, 100, 1'b0, 1'b0);
        send_sample(100, 0, 100, 1'b1, 1'b0);
        push_expected();
        wait_idle(2);

        // Abort in PROC at bin 2, then a fresh single-sample frame
        rand_w();
        start_frame();
        send_sample(50, -20, 7, 1'b0, 1'b0);
        cyc(); cyc();
        chk("abort_at_k2", w_bin_o, 2);
        abort_i = 1'b1;
        cyc();
        abort_i = 1'b0;
        chk("abort_busy", busy_o, 0);
        chk("abort_w_bin", w_bin_o, 0);
        chk("abort_s_ready", s_ready_o, 0);
        start_frame();
        send_sample(-9, 11, 5, 1'b1, 1'b0);
        push_expected();
        wait_idle(1);

        // Randomised frames under random back-pressure
        rdy_rand = 1'b1;
        for (int f = 0; f < 8; f++) begin
            n = int'($urandom_range(1, 5));
            start_frame();
            for (int s = 0; s < n; s++)
                send_sample(rnd_val(IW), rnd_val(IW), rnd_val(HW), s == n-1, 1'b1);
            push_expected();
            wait_idle(n);
        end

        // Reset pulse while OUT presents bin 2
        rdy_rand = 1'b0; rdy_force = 1'b0;
        rand_w();
        start_frame();
        send_sample(12, 34, 3, 1'b0, 1'b0);
        send_sample(-5, 6, 9, 1'b1, 1'b0);
        push_expected();
        wait_valid();
        rdy_force = 1'b1;
        cyc(); cyc();
        rdy_force = 1'b0;
        chk("rst_at_bin2", m_bin_o, 2);
        rst_ni = 1'b0;
        #1;
        chk("arst_m_valid", m_valid_o, 0);
        chk("arst_m_bin", m_bin_o, 0);
        chk("arst_m_real", m_real_o, 0);
        chk("arst_m_imag", m_imag_o, 0);
        chk("arst_m_last", m_last_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_count", count_o, 0);
        chk("arst_ovf", ovf_o, 0);
        exp_q.delete();
        cyc();
        rst_ni = 1'b1;
        rdy_force = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (m_valid_o || busy_o || s_ready_o) bad++;
        end
        chk("quiet_after_reset", bad, 0);
        start_frame();
        send_sample(7, -7, 2, 1'b1, 1'b1);
        push_expected();
        wait_idle(1);

        cyc(); cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
